// File: rtl/func4_sweep_checker.sv
// Exhaustive 16-vector sweep of two 4-input function blocks against a golden truth table.
// Reports per-DUT mismatch counts, fail masks and an overall pass flag.
module func4_sweep_checker #(
  parameter logic [15:0] TRUTH_TABLE   = 16'hB0E3,
  parameter int          SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  x_vec,
  input  logic        dut_a,
  input  logic        dut_b,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_cnt_a,
  output logic [4:0]  err_cnt_b,
  output logic [15:0] fail_mask_a,
  output logic [15:0] fail_mask_b
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state_r;
  logic [3:0] settle_cnt_r;
  logic       golden_s;
  logic       mis_a_s;
  logic       mis_b_s;

  // Golden bit for the vector currently on x_vec and per-DUT mismatch flags
  always_comb begin
    golden_s = TRUTH_TABLE[x_vec];
    mis_a_s  = dut_a ^ golden_s;
    mis_b_s  = dut_b ^ golden_s;
  end

  // Sweep sequencer and result accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= 4'd0;
      x_vec        <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_cnt_a    <= 5'd0;
      err_cnt_b    <= 5'd0;
      fail_mask_a  <= 16'd0;
      fail_mask_b  <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r      <= ST_SETTLE;
            settle_cnt_r <= SETTLE_INIT;
            x_vec        <= 4'd0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_cnt_a    <= 5'd0;
            err_cnt_b    <= 5'd0;
            fail_mask_a  <= 16'd0;
            fail_mask_b  <= 16'd0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_r == 4'd0) begin
            state_r <= ST_CHECK;
          end else begin
            settle_cnt_r <= settle_cnt_r - 4'd1;
          end
        end
        ST_CHECK: begin
          if (mis_a_s) begin
            err_cnt_a          <= err_cnt_a + 5'd1;
            fail_mask_a[x_vec] <= 1'b1;
          end
          if (mis_b_s) begin
            err_cnt_b          <= err_cnt_b + 5'd1;
            fail_mask_b[x_vec] <= 1'b1;
          end
          // Last vector: pass must fold in this cycle's comparison, not just the stored counts
          if (x_vec == 4'd15) begin
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_cnt_a == 5'd0) && (err_cnt_b == 5'd0) && !mis_a_s && !mis_b_s;
          end else begin
            x_vec        <= x_vec + 4'd1;
            settle_cnt_r <= SETTLE_INIT;
            state_r      <= ST_SETTLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          pass    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_func4_sweep_checker.sv
// Directed bench: behavioural DUT models feed two checker instances (settle 1 and 3);
// expected sweep results are queued at start and compared when done rises.
module tb_func4_sweep_checker;

  localparam logic [15:0] TT = 16'hB0E3;

  typedef struct {
    logic [4:0]  err_a;
    logic [4:0]  err_b;
    logic [15:0] mask_a;
    logic [15:0] mask_b;
    logic        pass;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  int   mode_a = 0;
  int   mode_b = 0;
  bit   sel = 1'b0;

  logic [3:0]  x_vec0, x_vec1;
  logic        dut_a0, dut_b0, dut_a1, dut_b1;
  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [4:0]  err_a0, err_b0, err_a1, err_b1;
  logic [15:0] mask_a0, mask_b0, mask_a1, mask_b1;

  logic [3:0]  o_x;
  logic        o_busy, o_done, o_pass;
  logic [4:0]  o_err_a, o_err_b;
  logic [15:0] o_mask_a, o_mask_b;

  int   passed = 0;
  int   total  = 0;
  int   failed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic resp(input int m, input logic [3:0] i);
    case (m)
      0:       return TT[i];
      1:       return ~TT[i];
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    dut_a0 = resp(mode_a, x_vec0);
    dut_b0 = resp(mode_b, x_vec0);
    dut_a1 = resp(mode_a, x_vec1);
    dut_b1 = resp(mode_b, x_vec1);
  end

  always_comb begin
    o_x      = sel ? x_vec1  : x_vec0;
    o_busy   = sel ? busy1   : busy0;
    o_done   = sel ? done1   : done0;
    o_pass   = sel ? pass1   : pass0;
    o_err_a  = sel ? err_a1  : err_a0;
    o_err_b  = sel ? err_b1  : err_b0;
    o_mask_a = sel ? mask_a1 : mask_a0;
    o_mask_b = sel ? mask_b1 : mask_b0;
  end

  func4_sweep_checker #(.TRUTH_TABLE(16'hB0E3), .SETTLE_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .x_vec(x_vec0), .dut_a(dut_a0), .dut_b(dut_b0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt_a(err_a0), .err_cnt_b(err_b0),
    .fail_mask_a(mask_a0), .fail_mask_b(mask_b0)
  );

  func4_sweep_checker #(.TRUTH_TABLE(16'hB0E3), .SETTLE_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .x_vec(x_vec1), .dut_a(dut_a1), .dut_b(dut_b1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt_a(err_a1), .err_cnt_b(err_b1),
    .fail_mask_a(mask_a1), .fail_mask_b(mask_b1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_x"}, 32'(o_x), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_done"}, 32'(o_done), 32'd0);
    chk({tag, "_pass"}, 32'(o_pass), 32'd0);
    chk({tag, "_erra"}, 32'(o_err_a), 32'd0);
    chk({tag, "_errb"}, 32'(o_err_b), 32'd0);
    chk({tag, "_maska"}, 32'(o_mask_a), 32'd0);
    chk({tag, "_maskb"}, 32'(o_mask_b), 32'd0);
  endtask

  // One sweep: queue the model's expectation, pulse start, watch for done, then compare.
  task automatic sweep(input string tag, input bit s, input int ma, input int mb,
                       input int pulse_at, input int rst_at);
    exp_t e;
    int   period;
    int   lat;
    period   = s ? 4 : 2;
    e.err_a  = 5'd0;
    e.err_b  = 5'd0;
    e.mask_a = 16'd0;
    e.mask_b = 16'd0;
    for (int i = 0; i < 16; i++) begin
      if (resp(ma, 4'(i)) != TT[i]) begin
        e.err_a++;
        e.mask_a[i] = 1'b1;
      end
      if (resp(mb, 4'(i)) != TT[i]) begin
        e.err_b++;
        e.mask_b[i] = 1'b1;
      end
    end
    e.pass = (e.err_a == 5'd0) && (e.err_b == 5'd0);
    e.lat  = 16 * period;
    sb.push_back(e);

    sel    = s;
    mode_a = ma;
    mode_b = mb;
    @(negedge clk);
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      if (n == 1) begin
        chk({tag, "_busy1"}, 32'(o_busy), 32'd1);
        chk({tag, "_done_clr"}, 32'(o_done), 32'd0);
        chk({tag, "_erra_clr"}, 32'(o_err_a), 32'd0);
        chk({tag, "_maskb_clr"}, 32'(o_mask_b), 32'd0);
      end
      if (n == 5 * period) chk({tag, "_xstep5"}, 32'(o_x), 32'd5);
      if (n == rst_at) begin
        chk({tag, "_x_at_rst"}, 32'(o_x), 32'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state({tag, "_rst"});
        e = sb.pop_front();
        return;
      end
      if (n == pulse_at) begin
        if (s) start1 = 1'b1; else start0 = 1'b1;
      end
      if (o_done) begin
        lat = n;
        break;
      end
    end
    start0 = 1'b0;
    start1 = 1'b0;
    e = sb.pop_front();
    chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
    chk({tag, "_busy_end"}, 32'(o_busy), 32'd0);
    chk({tag, "_x_end"}, 32'(o_x), 32'd15);
    chk({tag, "_pass"}, 32'(o_pass), 32'(e.pass));
    chk({tag, "_erra"}, 32'(o_err_a), 32'(e.err_a));
    chk({tag, "_errb"}, 32'(o_err_b), 32'(e.err_b));
    chk({tag, "_maska"}, 32'(o_mask_a), 32'(e.mask_a));
    chk({tag, "_maskb"}, 32'(o_mask_b), 32'(e.mask_b));
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_state("reset0");
    sel = 1'b1;
    #0;
    chk_reset_state("reset1");
    sel = 1'b0;
    @(negedge clk);

    sweep("golden",    1'b0, 0, 0, 0, 0);
    sweep("b_inv",     1'b0, 0, 1, 0, 0);
    sweep("a_stuck0",  1'b0, 2, 0, 0, 0);
    // restart from DONE after a failing sweep, with a start pulse ignored mid-sweep
    sweep("restart",   1'b0, 0, 0, 10, 0);
    sweep("rst_mid",   1'b0, 0, 0, 0, 14);
    sweep("after_rst", 1'b0, 0, 0, 0, 0);
    sweep("settle3",   1'b1, 0, 0, 0, 0);
    sweep("settle3_b", 1'b1, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
